poly_voice_allocator: RTL and testbench
=======================================

// Module: poly_voice_allocator
// PURPOSE
//  Polyphonic successor to the single-note control/datapath pair. Takes keyboard
//  note events, assigns each held key to one of NUM_VOICES voices, and keeps one
//  frequency word per voice, with oldest-voice stealing when all voices are busy.
//  Sits between convert_keyboard_input and a multi-voice audio/VGA back end.
// PARAMETERS
//  NUM_VOICES  4   voices; legal 2..16
//  FREQ_W      32  width of each voice frequency word; legal >= 12
// PORTS
//  clk           in   1                clock; single clock domain
//  reset         in   1                synchronous, active-high
//  ev_valid      in   1                event offered
//  ev_ready      out  1                event accepted when ev_valid&&ev_ready at posedge
//  ev_on         in   1                1 = note-on (make), 0 = note-off (break)
//  ev_note       in   4                semitone 0..11 (C..B); 12..15 invalid
//  ev_octave     in   2                octave shift 0..3
//  voice_active  out  NUM_VOICES       bit v = voice v sounding
//  voice_freq    out  NUM_VOICES*FREQ_W  voice v at [v*FREQ_W +: FREQ_W], Hz
//  voice_key     out  NUM_VOICES*6     voice v {octave,note} at [v*6 +: 6]
//  stolen        out  1                1-cycle pulse: commit replaced an active voice
//  drop          out  1                1-cycle pulse: invalid note consumed, no effect
// BEHAVIOUR
//  Reset: voice_active, voice_freq, voice_key, ranks = 0; stolen=drop=0; FSM IDLE;
//   ev_ready=0 during reset, 1 on the first cycle after reset deasserts.
//  FSM: IDLE -(accept)-> LOOKUP -> COMMIT -> IDLE. ev_ready = (state==IDLE).
//   Event latched on accept (cycle T). LOOKUP (T+1) registers match mask, lowest
//   free index, oldest index. COMMIT (T+2) updates voice state; new outputs visible
//   from T+3. Max one event every 3 cycles. ev_* ignored outside IDLE.
//  Key match: voice active and voice_key == {ev_octave,ev_note}.
//  Frequency: BASE[note] << octave, zero-extended to FREQ_W. BASE = 262,277,294,
//   311,330,349,370,392,415,440,466,494 (C4..B4). Max 3952 fits 12 bits.
//  Age rank per voice: active ranks always a permutation of 0..k-1 (k = active
//   count); 0 = newest. Inactive voices have rank 0 and are ignored.
//  COMMIT, note-on, key matched (voice m): retrigger; freq unchanged; m rank->0;
//   active voices with rank < old rank(m) increment. No stolen pulse.
//  COMMIT, note-on, no match, free voice exists: lowest free index f gets key,
//   freq, active=1, rank 0; all other active ranks increment.
//  COMMIT, note-on, no match, all active: oldest voice o (rank NUM_VOICES-1)
//   overwritten with new key/freq, rank 0; all others increment; stolen=1.
//  COMMIT, note-off, matched voice m: active=0, freq=0, key retained, rank->0;
//   active voices with rank > old rank(m) decrement.
//  COMMIT, note-off, no match: no state change, no pulse.
//  Invalid note (12..15), either polarity: consumed normally (3-cycle path), no
//   state change, drop=1 in COMMIT cycle.
//  At most one voice ever holds a given key (retrigger guarantees it).
//  Reset mid-operation (LOOKUP/COMMIT): event abandoned, full reset state, no pulse.
// TESTING
//  1 Reset, on(9,0) -> voice0 active, freq0=440, key0=0x09, visible 3 cycles after accept.
//  2 on(0,0),on(4,1),on(7,2),on(11,3) -> active=4'hF, freqs 262,660,1568,3952.
//  3 Full (test 2), on(2,0) -> voice0 (oldest) freq=294, stolen pulse 1 cycle.
//  4 off(4,1) with 4 active -> voice1 inactive, freq1=0; next on(5,0) lands in voice1.
//  5 on(9,0) twice -> single voice active, ranks unchanged count; on(13,0) -> drop pulse,
//    outputs unchanged; off(3,2) unheld -> no change.
//  6 Assert reset during LOOKUP of on(9,0) -> all outputs 0, ev_ready=1 after release.

Source files
------------

// File: rtl/poly_voice_allocator.sv
// rtl/poly_voice_allocator.sv - keyboard note events to NUM_VOICES voices with oldest-voice stealing
module poly_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int FREQ_W     = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_ev_valid,
    output logic                         o_ev_ready,
    input  logic                         i_ev_on,
    input  logic [3:0]                   i_ev_note,
    input  logic [1:0]                   i_ev_octave,
    output logic [NUM_VOICES-1:0]        o_voice_active,
    output logic [NUM_VOICES*FREQ_W-1:0] o_voice_freq,
    output logic [NUM_VOICES*6-1:0]      o_voice_key,
    output logic                         o_stolen,
    output logic                         o_drop
);

    localparam int RW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_ev_ready;
    logic                r_stolen;
    logic                r_drop;

    // Event captured on accept; {octave,note} layout matches the voice key
    logic                r_ev_on;
    logic [5:0]          r_ev_key;

    // Lookup results registered in LOOKUP, consumed in COMMIT
    logic                r_invalid;
    logic                r_match_hit;
    logic                r_free_hit;
    logic [RW-1:0]       r_match_idx;
    logic [RW-1:0]       r_free_idx;
    logic [RW-1:0]       r_oldest_idx;

    // Per-voice state; rank 0 = most recently started, inactive voices hold rank 0
    logic [NUM_VOICES-1:0] r_active;
    logic [FREQ_W-1:0]     r_freq [NUM_VOICES];
    logic [5:0]            r_key  [NUM_VOICES];
    logic [RW-1:0]         r_rank [NUM_VOICES];

    logic                w_invalid;
    logic                w_match_hit;
    logic                w_free_hit;
    logic [RW-1:0]       w_match_idx;
    logic [RW-1:0]       w_free_idx;
    logic [RW-1:0]       w_oldest_idx;
    logic [RW-1:0]       w_match_rank;
    logic [RW-1:0]       w_tgt_idx;
    logic [11:0]         w_base;
    logic [FREQ_W-1:0]   w_new_freq;

    // C4..B4 in Hz; octave shift is applied afterwards
    function automatic logic [11:0] base_freq(input logic [3:0] note);
        case (note)
            4'd0:    base_freq = 12'd262;
            4'd1:    base_freq = 12'd277;
            4'd2:    base_freq = 12'd294;
            4'd3:    base_freq = 12'd311;
            4'd4:    base_freq = 12'd330;
            4'd5:    base_freq = 12'd349;
            4'd6:    base_freq = 12'd370;
            4'd7:    base_freq = 12'd392;
            4'd8:    base_freq = 12'd415;
            4'd9:    base_freq = 12'd440;
            4'd10:   base_freq = 12'd466;
            4'd11:   base_freq = 12'd494;
            default: base_freq = 12'd0;
        endcase
    endfunction

    // Key match, lowest free voice and oldest voice; descending scan lets the lowest index win
    always_comb begin
        w_match_hit  = 1'b0;
        w_match_idx  = '0;
        w_free_hit   = 1'b0;
        w_free_idx   = '0;
        w_oldest_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_active[v] && (r_key[v] == r_ev_key)) begin
                w_match_hit = 1'b1;
                w_match_idx = RW'(v);
            end
            if (!r_active[v]) begin
                w_free_hit = 1'b1;
                w_free_idx = RW'(v);
            end
            if (r_active[v] && (r_rank[v] == RW'(NUM_VOICES - 1))) begin
                w_oldest_idx = RW'(v);
            end
        end
    end

    // Frequency word for the latched key, rank of the matched voice and the allocation target
    always_comb begin
        w_invalid    = (r_ev_key[3:0] > 4'd11);
        w_base       = base_freq(r_ev_key[3:0]);
        w_new_freq   = FREQ_W'(w_base) << r_ev_key[5:4];
        w_match_rank = r_rank[r_match_idx];
        w_tgt_idx    = r_free_hit ? r_free_idx : r_oldest_idx;
    end

    // Control FSM: accept, lookup, commit; ready and pulses are registered
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_ev_ready   <= 1'b0;
            r_stolen     <= 1'b0;
            r_drop       <= 1'b0;
            r_ev_on      <= 1'b0;
            r_ev_key     <= '0;
            r_invalid    <= 1'b0;
            r_match_hit  <= 1'b0;
            r_free_hit   <= 1'b0;
            r_match_idx  <= '0;
            r_free_idx   <= '0;
            r_oldest_idx <= '0;
        end else begin
            r_stolen <= 1'b0;
            r_drop   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ev_ready <= 1'b1;
                    if (i_ev_valid && r_ev_ready) begin
                        r_ev_on    <= i_ev_on;
                        r_ev_key   <= {i_ev_octave, i_ev_note};
                        r_ev_ready <= 1'b0;
                        r_state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_invalid    <= w_invalid;
                    r_match_hit  <= w_match_hit;
                    r_free_hit   <= w_free_hit;
                    r_match_idx  <= w_match_idx;
                    r_free_idx   <= w_free_idx;
                    r_oldest_idx <= w_oldest_idx;
                    // Pulses line up with the COMMIT cycle that acts on this event
                    r_stolen     <= !w_invalid && r_ev_on && !w_match_hit && !w_free_hit;
                    r_drop       <= w_invalid;
                    r_state      <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_ev_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_ev_ready <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Voice table update in COMMIT: retrigger, allocate/steal on note-on, release on note-off
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_active <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_freq[v] <= '0;
                r_key[v]  <= '0;
                r_rank[v] <= '0;
            end
        end else if ((r_state == ST_COMMIT) && !r_invalid) begin
            if (r_ev_on && r_match_hit) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (RW'(v) == r_match_idx) begin
                        r_rank[v] <= '0;
                    end else if (r_active[v] && (r_rank[v] < w_match_rank)) begin
                        r_rank[v] <= r_rank[v] + RW'(1);
                    end
                end
            end else if (r_ev_on) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (RW'(v) == w_tgt_idx) begin
                        r_active[v] <= 1'b1;
                        r_key[v]    <= r_ev_key;
                        r_freq[v]   <= w_new_freq;
                        r_rank[v]   <= '0;
                    end else if (r_active[v]) begin
                        r_rank[v] <= r_rank[v] + RW'(1);
                    end
                end
            end else if (r_match_hit) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (RW'(v) == r_match_idx) begin
                        r_active[v] <= 1'b0;
                        r_freq[v]   <= '0;
                        r_rank[v]   <= '0;
                    end else if (r_active[v] && (r_rank[v] > w_match_rank)) begin
                        r_rank[v] <= r_rank[v] - RW'(1);
                    end
                end
            end
        end
    end

    assign o_ev_ready     = r_ev_ready;
    assign o_stolen       = r_stolen;
    assign o_drop         = r_drop;
    assign o_voice_active = r_active;

    genvar g;
    generate
        for (g = 0; g < NUM_VOICES; g++) begin : g_voice_out
            assign o_voice_freq[g*FREQ_W +: FREQ_W] = r_freq[g];
            assign o_voice_key[g*6 +: 6]            = r_key[g];
        end
    endgenerate

endmodule

// File: tb/tb_poly_voice_allocator.sv
// tb/tb_poly_voice_allocator.sv - directed bench for poly_voice_allocator
module tb_poly_voice_allocator;

    localparam int NV = 4;
    localparam int FW = 32;

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_ev_valid;
    logic             o_ev_ready;
    logic             i_ev_on;
    logic [3:0]       i_ev_note;
    logic [1:0]       i_ev_octave;
    logic [NV-1:0]    o_voice_active;
    logic [NV*FW-1:0] o_voice_freq;
    logic [NV*6-1:0]  o_voice_key;
    logic             o_stolen;
    logic             o_drop;

    int n_checks = 0;
    int n_fail   = 0;

    logic       st;
    logic       dr;
    logic [3:0] ac;

    always #5 clk = ~clk;

    poly_voice_allocator #(
        .NUM_VOICES (NV),
        .FREQ_W     (FW)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_ev_valid     (i_ev_valid),
        .o_ev_ready     (o_ev_ready),
        .i_ev_on        (i_ev_on),
        .i_ev_note      (i_ev_note),
        .i_ev_octave    (i_ev_octave),
        .o_voice_active (o_voice_active),
        .o_voice_freq   (o_voice_freq),
        .o_voice_key    (o_voice_key),
        .o_stolen       (o_stolen),
        .o_drop         (o_drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [31:0] fq(input int v);
        return o_voice_freq[v*FW +: FW];
    endfunction

    function automatic logic [31:0] ky(input int v);
        return 32'(o_voice_key[v*6 +: 6]);
    endfunction

    task automatic do_reset();
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(o_ev_ready), 0);
        check("rst_active", 32'(o_voice_active), 0);
        check("rst_pulses", 32'({o_stolen, o_drop}), 0);
        for (int v = 0; v < NV; v++) begin
            check($sformatf("rst_freq%0d", v), fq(v), 0);
            check($sformatf("rst_key%0d", v), ky(v), 0);
        end
        i_reset = 1'b0;
        @(negedge clk);
        check("rst_ready_after", 32'(o_ev_ready), 1);
    endtask

    // Called at a negedge; returns pulses and active mask seen in the COMMIT cycle
    task automatic do_event(input logic on, input logic [3:0] note, input logic [1:0] oct,
                            output logic stolen_c, output logic drop_c, output logic [3:0] act_c);
        int n;
        n = 0;
        while (!o_ev_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 0, 1);
        i_ev_valid  = 1'b1;
        i_ev_on     = on;
        i_ev_note   = note;
        i_ev_octave = oct;
        @(negedge clk);
        i_ev_valid = 1'b0;
        @(negedge clk);
        stolen_c = o_stolen;
        drop_c   = o_drop;
        act_c    = o_voice_active;
        @(negedge clk);
        check("pulse_clear", 32'({o_stolen, o_drop}), 0);
    endtask

    initial begin
        i_reset     = 1'b1;
        i_ev_valid  = 1'b0;
        i_ev_on     = 1'b0;
        i_ev_note   = 4'd0;
        i_ev_octave = 2'd0;
        @(negedge clk);

        // 1: single note-on, visible only after COMMIT
        do_reset();
        do_event(1'b1, 4'd9, 2'd0, st, dr, ac);
        check("t1_act_at_commit", 32'(ac), 0);
        check("t1_active", 32'(o_voice_active), 32'h1);
        check("t1_freq0", fq(0), 440);
        check("t1_key0", ky(0), 32'h09);
        check("t1_stolen", 32'(st), 0);

        // 2: fill all voices across octaves
        do_reset();
        do_event(1'b1, 4'd0, 2'd0, st, dr, ac);
        do_event(1'b1, 4'd4, 2'd1, st, dr, ac);
        do_event(1'b1, 4'd7, 2'd2, st, dr, ac);
        do_event(1'b1, 4'd11, 2'd3, st, dr, ac);
        check("t2_active", 32'(o_voice_active), 32'hF);
        check("t2_freq0", fq(0), 262);
        check("t2_freq1", fq(1), 660);
        check("t2_freq2", fq(2), 1568);
        check("t2_freq3", fq(3), 3952);
        check("t2_key3", ky(3), 32'h3B);
        check("t2_stolen", 32'(st), 0);

        // 3: steal the oldest voice
        do_event(1'b1, 4'd2, 2'd0, st, dr, ac);
        check("t3_stolen", 32'(st), 1);
        check("t3_freq0", fq(0), 294);
        check("t3_key0", ky(0), 32'h02);
        check("t3_freq1", fq(1), 660);
        check("t3_active", 32'(o_voice_active), 32'hF);

        // 4: release voice1, then reuse it as the lowest free slot
        do_event(1'b0, 4'd4, 2'd1, st, dr, ac);
        check("t4_active_off", 32'(o_voice_active), 32'hD);
        check("t4_freq1_off", fq(1), 0);
        check("t4_key1_kept", ky(1), 32'h14);
        do_event(1'b1, 4'd5, 2'd0, st, dr, ac);
        check("t4_active_on", 32'(o_voice_active), 32'hF);
        check("t4_freq1_on", fq(1), 349);
        check("t4_key1_on", ky(1), 32'h05);
        check("t4_stolen", 32'(st), 0);

        // Retrigger the oldest voice, so the next steal must pick a different one
        do_event(1'b1, 4'd7, 2'd2, st, dr, ac);
        check("t4r_stolen", 32'(st), 0);
        check("t4r_freq2", fq(2), 1568);
        do_event(1'b1, 4'd1, 2'd0, st, dr, ac);
        check("t4s_stolen", 32'(st), 1);
        check("t4s_freq3", fq(3), 277);
        check("t4s_key3", ky(3), 32'h01);
        check("t4s_freq2", fq(2), 1568);
        check("t4s_freq0", fq(0), 294);

        // 5: retrigger, invalid note, unheld note-off
        do_reset();
        do_event(1'b1, 4'd9, 2'd0, st, dr, ac);
        do_event(1'b1, 4'd9, 2'd0, st, dr, ac);
        check("t5_retrig_active", 32'(o_voice_active), 32'h1);
        check("t5_retrig_stolen", 32'(st), 0);
        check("t5_freq1", fq(1), 0);
        do_event(1'b1, 4'd13, 2'd0, st, dr, ac);
        check("t5_drop", 32'(dr), 1);
        check("t5_drop_active", 32'(o_voice_active), 32'h1);
        check("t5_drop_freq0", fq(0), 440);
        do_event(1'b0, 4'd3, 2'd2, st, dr, ac);
        check("t5_unheld_pulses", 32'({st, dr}), 0);
        check("t5_unheld_active", 32'(o_voice_active), 32'h1);
        do_event(1'b0, 4'd9, 2'd0, st, dr, ac);
        check("t5_off_active", 32'(o_voice_active), 0);
        check("t5_off_freq0", fq(0), 0);
        check("t5_off_key0", ky(0), 32'h09);
        do_event(1'b1, 4'd2, 2'd0, st, dr, ac);
        check("t5_reuse_freq0", fq(0), 294);

        // 6: reset during LOOKUP abandons the event
        do_reset();
        i_ev_valid  = 1'b1;
        i_ev_on     = 1'b1;
        i_ev_note   = 4'd9;
        i_ev_octave = 2'd0;
        @(negedge clk);
        i_ev_valid = 1'b0;
        i_reset    = 1'b1;
        @(negedge clk);
        check("t6_ready_in_rst", 32'(o_ev_ready), 0);
        check("t6_active_in_rst", 32'(o_voice_active), 0);
        i_reset = 1'b0;
        @(negedge clk);
        check("t6_ready_after", 32'(o_ev_ready), 1);
        repeat (3) begin
            check("t6_active_idle", 32'(o_voice_active), 0);
            check("t6_pulses_idle", 32'({o_stolen, o_drop}), 0);
            check("t6_freq0_idle", fq(0), 0);
            @(negedge clk);
        end
        do_event(1'b1, 4'd4, 2'd1, st, dr, ac);
        check("t6_after_freq0", fq(0), 660);
        check("t6_after_active", 32'(o_voice_active), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
